// File: rtl/seven_seg_pkg.sv
// Shared types and pin constants for the two-digit seven-segment scan driver.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    BLANK_L = 2'd0,
    SHOW_L  = 2'd1,
    BLANK_R = 2'd2,
    SHOW_R  = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [1:0] DIGIT_OFF   = 2'b11;
  localparam logic [1:0] DIGIT_LEFT  = 2'b01;
  localparam logic [1:0] DIGIT_RIGHT = 2'b10;

  // Field positions within one digit byte: dp on top, g..a below.
  localparam int unsigned DP_BIT  = 7;
  localparam int unsigned SEG_MSB = 6;

endpackage

// File: rtl/seg_slot_timer.sv
// Digit-slot counter: wraps every SCAN_DIV cycles, flags the blank window and slot edges.
module seg_slot_timer #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic in_blank,
  output logic blank_done,
  output logic slot_start,
  output logic slot_end,
  output logic hold
);

  localparam int unsigned     CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   LAST      = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0]   BLANK_LST = CW'(BLANK_CYCLES - 1);

  if (SCAN_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_params
    $error("seg_slot_timer: need SCAN_DIV >= 2 and 1 <= BLANK_CYCLES < SCAN_DIV");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    hold       = ~enable;
    in_blank   = (cnt < BLANK_END);
    blank_done = (cnt == BLANK_LST);
    slot_start = (cnt == '0);
    slot_end   = (cnt == LAST);
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Double-buffered two-digit common-anode scan driver with anti-ghosting blank slots.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic [15:0] encodedValue,
  input  logic        load,
  input  logic        enable,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [1:0]  digit_n,
  output logic        frame_tick
);

  scan_state_t state, state_next;
  logic [15:0] pending, active;
  logic        in_blank, blank_done, slot_start, slot_end, hold;
  logic        frame_start;

  seg_slot_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clock),
    .rst_n      (clear_n),
    .enable     (enable),
    .in_blank   (in_blank),
    .blank_done (blank_done),
    .slot_start (slot_start),
    .slot_end   (slot_end),
    .hold       (hold)
  );

  always_comb begin
    state_next = state;
    case (state)
      BLANK_L: if (blank_done) state_next = SHOW_L;
      SHOW_L:  if (slot_end)   state_next = BLANK_R;
      BLANK_R: if (blank_done) state_next = SHOW_R;
      SHOW_R:  if (slot_end)   state_next = BLANK_L;
      default:                 state_next = BLANK_L;
    endcase
  end

  assign frame_start = !hold && (state == BLANK_L) && slot_start;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= BLANK_L;
    end else if (hold) begin
      state <= BLANK_L;
    end else begin
      state <= state_next;
    end
  end

  // A load coinciding with the frame start bypasses pending so it shows this frame.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pending <= '0;
      active  <= '0;
    end else begin
      if (load) begin
        pending <= encodedValue;
      end
      if (frame_start) begin
        active <= load ? encodedValue : pending;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      digit_n    <= DIGIT_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      digit_n    <= DIGIT_OFF;
      frame_tick <= !hold && (state == SHOW_R) && slot_end;
      if (!hold && !in_blank) begin
        case (state)
          SHOW_L: begin
            seg_n   <= ~active[8+SEG_MSB:8];
            dp_n    <= ~active[8+DP_BIT];
            digit_n <= DIGIT_LEFT;
          end
          SHOW_R: begin
            seg_n   <= ~active[SEG_MSB:0];
            dp_n    <= ~active[DP_BIT];
            digit_n <= DIGIT_RIGHT;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2 (16-cycle frame).
module tb_seven_seg_scan_driver;

  logic        clock = 1'b0;
  logic        clear_n;
  logic [15:0] encodedValue;
  logic        load;
  logic        enable;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [1:0]  digit_n;
  logic        frame_tick;

  seven_seg_scan_driver #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .encodedValue (encodedValue),
    .load         (load),
    .enable       (enable),
    .seg_n        (seg_n),
    .dp_n         (dp_n),
    .digit_n      (digit_n),
    .frame_tick   (frame_tick)
  );

  always #5 clock = ~clock;

  // Expected pins visible after rising edge number cyc.
  typedef struct packed {
    int         cyc;
    int         stage;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] dig;
    logic       tick;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (e.cyc < edge_cnt) begin
        bad++;
        $display("FAIL late_s%0d cyc=%0d expectation queued after its cycle (now %0d)",
                 e.stage, e.cyc, edge_cnt);
      end else if ({seg_n, dp_n, digit_n, frame_tick} !== {e.seg, e.dp, e.dig, e.tick}) begin
        bad++;
        $display("FAIL pins_s%0d cyc=%0d got seg=%h dp=%b dig=%b tick=%b want seg=%h dp=%b dig=%b tick=%b",
                 e.stage, e.cyc, seg_n, dp_n, digit_n, frame_tick, e.seg, e.dp, e.dig, e.tick);
      end
    end
  end

  task automatic push_exp(input int cyc, input int stage, input logic [6:0] seg,
                          input logic dp, input logic [1:0] dig, input logic tick);
    exp_t e;
    e.cyc = cyc; e.stage = stage; e.seg = seg; e.dp = dp; e.dig = dig; e.tick = tick;
    sb.push_back(e);
  endtask

  // Frame starting at edge f: blank p0-1, left p2-7, blank p8-9, right p10-15, tick at p15.
  task automatic push_frame(input int f, input int stage, input logic [6:0] lseg, input logic ldp,
                            input logic [6:0] rseg, input logic rdp, input int n);
    for (int p = 0; p < n; p++) begin
      if (p >= 2 && p <= 7)
        push_exp(f + p, stage, lseg, ldp, 2'b01, 1'b0);
      else if (p >= 10 && p <= 15)
        push_exp(f + p, stage, rseg, rdp, 2'b10, p == 15);
      else
        push_exp(f + p, stage, 7'h7F, 1'b1, 2'b11, 1'b0);
    end
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load_at(input int k, input logic [15:0] v);
    wait_edge(k - 1);
    encodedValue = v;
    load = 1'b1;
    wait_edge(k);
    load = 1'b0;
  endtask

  initial begin
    clear_n      = 1'b1;
    enable       = 1'b1;
    load         = 1'b0;
    encodedValue = 16'h0000;
    #2 clear_n = 1'b0;

    // Stage 0: reset holds every pin dark.
    for (int c = 1; c <= 3; c++) push_exp(c, 0, 7'h7F, 1'b1, 2'b11, 1'b0);
    wait_edge(3);
    clear_n = 1'b1;

    // Stage 1/2: first frame (edge 4) shows zero; 6D6D loaded mid-frame appears next frame.
    push_frame(4,  1, 7'h7F, 1'b1, 7'h7F, 1'b1, 16);
    push_frame(20, 2, 7'h12, 1'b1, 7'h12, 1'b1, 16);
    load_at(8, 16'h6D6D);

    // Stage 3: distinct digits.
    push_frame(36, 3, 7'h79, 1'b1, 7'h19, 1'b1, 16);
    load_at(25, 16'h0666);

    // Stage 4: load during SHOW_L of frame 36 leaves it intact; next frame blank.
    push_frame(52, 4, 7'h7F, 1'b1, 7'h7F, 1'b1, 16);
    load_at(40, 16'h0000);

    // Stage 5: load on the frame-start edge bypasses into the same frame.
    push_frame(68, 5, 7'h08, 1'b1, 7'h47, 1'b1, 16);
    load_at(68, 16'h7738);

    // Stage 6: enable dropped at p=4 of frame 84 for 5 edges; load while disabled.
    push_frame(84, 6, 7'h08, 1'b1, 7'h47, 1'b1, 4);
    for (int c = 88; c <= 92; c++) push_exp(c, 6, 7'h7F, 1'b1, 2'b11, 1'b0);
    // Stage 7: restart at edge 93 with dp-only left digit.
    push_frame(93,  7, 7'h7F, 1'b0, 7'h7F, 1'b1, 16);
    push_frame(109, 7, 7'h7F, 1'b0, 7'h7F, 1'b1, 16);
    wait_edge(87);
    enable = 1'b0;
    load_at(90, 16'h8000);
    wait_edge(92);
    enable = 1'b1;

    wait_edge(126);
    @(negedge clock);
    if (sb.size() != 0) begin
      $display("FAIL unchecked %0d expectations never reached", sb.size());
      total += sb.size();
      bad   += sb.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed driver for the board's two-digit common-anode seven-segment display. It sits directly downstream of the seven-segment encoder and consumes that encoder's 16-bit two-digit segment pattern. It double-buffers the pattern so a frame never shows half of an old value and half of a new one. It scans the two digits with a programmable slot period and an anti-ghosting blank interval, and drives active-low segment, decimal-point and digit-enable pins.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles per digit slot (1 kHz slot rate at 50 MHz). Must be at least 2.
- `BLANK_CYCLES`, default 500: cycles at the start of each slot with all digits off. Must satisfy 1 <= BLANK_CYCLES < SCAN_DIV. Any other value is an elaboration error.

Ports:
- `clock`  in  1: single clock; every flop is on its rising edge.
- `clear_n`  in  1: reset, asynchronous and active-low.
- `encodedValue`  in  16: segment pattern from the encoder.
  - [15:8] drives the left digit, [7:0] the right digit.
  - Per byte: bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a. A set bit means the segment is lit.
- `load`  in  1: single-cycle strobe that captures `encodedValue` into the pending register.
- `enable`  in  1: scanning enable. When low, the display is dark and the scan is held.
- `seg_n`  out  7: segments g..a, active-low.
- `dp_n`  out  1: decimal point, active-low.
- `digit_n`  out  2: digit enables, active-low. Bit 1 = left digit, bit 0 = right digit.
- `frame_tick`  out  1: one-cycle pulse once per completed frame.

## Operation
- Registers:
  - `pending[15:0]` is written by `load`.
  - `active[15:0]` is the value being displayed.
  - Slot counter of width $clog2(SCAN_DIV).
  - State register.
- FSM states, in order: BLANK_L -> SHOW_L -> BLANK_R -> SHOW_R -> BLANK_L.
  - Each BLANK state lasts BLANK_CYCLES cycles and each SHOW state lasts SCAN_DIV-BLANK_CYCLES cycles.
  - One frame is 2*SCAN_DIV cycles.
- Transfer:
  - At the first cycle of BLANK_L in every frame, `active` <= `pending`.
  - If `load` is high in that same cycle, `active` takes `encodedValue` directly (bypass), and `pending` also takes it.
- `load` in any other cycle updates only `pending`. The displayed value changes at the next frame boundary.
- Pin outputs:
  - In SHOW_L: `seg_n`=~active[14:8], `dp_n`=~active[15], `digit_n`=2'b01.
  - In SHOW_R: `seg_n`=~active[6:0], `dp_n`=~active[7], `digit_n`=2'b10.
  - In BLANK states: `seg_n`=7'h7F, `dp_n`=1, `digit_n`=2'b11.
- `frame_tick` asserts for the cycle that follows the last SHOW_R cycle.
- `enable` low:
  - The FSM is forced to BLANK_L with the counter at 0, and all pins go dark on the next cycle.
  - `load` still updates `pending`.
  - When `enable` returns high, the first enabled cycle is a frame start, so the transfer rule applies.
- `enable` dropped mid-SHOW: the digit goes dark one cycle later and no `frame_tick` is issued.

## Timing
- Reset (`clear_n` low), asynchronous:
  - `pending`=`active`=16'h0000, state BLANK_L, counter 0.
  - `seg_n`=7'h7F, `dp_n`=1, `digit_n`=2'b11, `frame_tick`=0.
- All outputs are registered. Pins reflect the state and counter of the previous cycle (1-cycle latency).
- Cycle numbering: cycle 1 is the first rising edge with `clear_n` high and `enable` high. Slot position p=(c-1) mod 2*SCAN_DIV.
- State by slot position:
  - SHOW_L for p in [BLANK_CYCLES, SCAN_DIV-1].
  - SHOW_R for p in [SCAN_DIV+BLANK_CYCLES, 2*SCAN_DIV-1].
- `load` to display latency: at most one frame plus 1+BLANK_CYCLES cycles. A load on a frame-start cycle lights at p=BLANK_CYCLES+1.
- Counter wraps from SCAN_DIV-1 to 0 at each slot change. No other terminal value exists.
- Reset asserted mid-frame clears everything immediately. Outputs are dark while `clear_n` is low.

## Structure
- Package `seven_seg_pkg`:
  - FSM state enum.
  - `SEG_BLANK` = 7'h7F.
  - `DIGIT_OFF` = 2'b11.
  - Byte field positions: `DP_BIT`=7, segment field [6:0].
- One sub-module, `seg_slot_timer`:
  - Parameterised SCAN_DIV/BLANK_CYCLES counter.
  - Outputs `in_blank`, `slot_end` and `hold` (hold when `enable` low).
  - The FSM and output registers stay in the top.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK_CYCLES=2, so one frame is 16 cycles.
- Reset check: hold `clear_n` low.
  - Required: `seg_n`=7'h7F, `dp_n`=1, `digit_n`=2'b11, `frame_tick`=0.
  - Release with `enable`=1 and no load: cycles 4–9 have `digit_n`=2'b01 with `seg_n`=7'h7F (active=0). `frame_tick` is high in cycle 17 only.
- Load before frame: `load` with 16'h6D6D at cycle 5.
  - Required: the first frame shows blank segments.
  - In cycles 20–25 and 28–33: `seg_n`=7'h12, `dp_n`=1.
- Distinct digits: load 16'h0666.
  - Required: left `seg_n`=7'h79, right `seg_n`=7'h19.
  - `digit_n` is 2'b11 for exactly 2 cycles between the two digits.
- Bypass on frame-start: `load` of 16'h7738 in a cycle where p=0.
  - Required: the same frame shows left 7'h08, right 7'h47.
- Load during SHOW_L: 16'h0666 already displayed, then `load` of 16'h0000 during SHOW_L.
  - Required: the current frame still shows 7'h79 and 7'h19. The next frame is blank.
- Enable low mid-frame: drop `enable` mid-SHOW_L, hold for 5 cycles, then raise it.
  - Required: `digit_n`=2'b11 from the next cycle, no `frame_tick`.
  - The scan restarts at BLANK_L, and the left digit re-lights 3 cycles after `enable` rises.
- Dp bit: load 16'h8000.
  - Required: left `dp_n`=0 with `seg_n`=7'h7F. Right `dp_n`=1.
